// File: rtl/mem_req_unit_pkg.sv
// Shared types and default sizes for the core-to-memory request unit.
package mem_req_unit_pkg;

  localparam int ADDR_W_DEF      = 32;
  localparam int DATA_W_DEF      = 32;
  localparam int TIMEOUT_CYC_DEF = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mem_req_unit_tmo_cnt.sv
// Wait-cycle counter for the request timeout; tc flags the last allowed wait cycle.
module mem_tmo_cnt #(
  parameter int LIMIT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tc
);

  logic [7:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 8'd1;
    end
  end

  // cnt holds the waits already completed, so this cycle's wait is the LIMIT-th.
  assign tc = (cnt == 8'(LIMIT - 1));

endmodule

// File: rtl/mem_req_unit.sv
// Single-outstanding core-to-memory request unit (IDLE -> REQ -> DONE).
// Optional timeout enabled by defining MEM_REQ_TIMEOUT_EN.
module mem_req_unit
  import mem_req_unit_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_adr,
  input  logic [DATA_W-1:0] core_wdata,
  output logic [DATA_W-1:0] core_rdata,
  output logic              core_stall,
  output logic              mem_valid,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_adr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              err,
  output state_t            dbg_state
);

  // Handshake: a request is presented while mem_valid is high and completes in
  // the first cycle mem_ready is also high; mem_we/mem_adr/mem_wdata do not move
  // until then. mem_ready outside that window is ignored.

  if (TIMEOUT_CYC < 2 || TIMEOUT_CYC > 255) begin : g_bad_timeout
    $error("mem_req_unit: TIMEOUT_CYC out of range 2..255");
  end

  state_t state, state_n;
  logic   load_req, load_rdata, tmo, tmo_hit;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n    = state;
    core_stall = 1'b0;
    mem_valid  = 1'b0;
    load_req   = 1'b0;
    load_rdata = 1'b0;
    tmo        = 1'b0;
    case (state)
      IDLE: begin
        if (core_req) begin
          core_stall = 1'b1;
          load_req   = 1'b1;
          state_n    = REQ;
        end
      end
      REQ: begin
        core_stall = 1'b1;
        mem_valid  = 1'b1;
        // A completion on the last allowed wait cycle wins over the timeout.
        if (mem_ready) begin
          load_rdata = ~mem_we;
          state_n    = DONE;
        end else if (tmo_hit) begin
          tmo     = 1'b1;
          state_n = DONE;
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_we    <= 1'b0;
      mem_adr   <= '0;
      mem_wdata <= '0;
    end else if (load_req) begin
      mem_we    <= core_we;
      mem_adr   <= core_adr;
      mem_wdata <= core_wdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      core_rdata <= '0;
    end else if (load_rdata) begin
      core_rdata <= mem_rdata;
    end else if (tmo) begin
      core_rdata <= '0;
    end
  end

`ifdef MEM_REQ_TIMEOUT_EN
  mem_tmo_cnt #(
    .LIMIT (TIMEOUT_CYC)
  ) u_tmo_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (load_req),
    .en    ((state == REQ) && !mem_ready),
    .tc    (tmo_hit)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err <= 1'b0;
    end else if (tmo) begin
      err <= 1'b1;
    end
  end
`else
  assign tmo_hit = 1'b0;
  assign err     = 1'b0;
`endif

  assign dbg_state = state;

endmodule

// File: doc/mem_req_unit.md
MEM_REQ_UNIT -- requirements
Module: mem_req_unit

Interface
REQ-001 Parameter ADDR_W, default 32: address width, core and memory side.
REQ-002 Parameter DATA_W, default 32: data width, core and memory side.
REQ-003 Parameter TIMEOUT_CYC, default 16: wait-cycle limit; legal range 2..255.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 core_req  input  1  core requests a memory access this cycle.
REQ-007 core_we  input  1  1 = write, 0 = read.
REQ-008 core_adr  input  ADDR_W  core access address.
REQ-009 core_wdata  input  DATA_W  core write data.
REQ-010 core_rdata  output  DATA_W  registered read data returned to core.
REQ-011 core_stall  output  1  core shall hold its state and its request while this is high.
REQ-012 mem_valid  output  1  memory request valid.
REQ-013 mem_we  output  1  registered write enable.
REQ-014 mem_adr  output  ADDR_W  registered address.
REQ-015 mem_wdata  output  DATA_W  registered write data.
REQ-016 mem_ready  input  1  memory accepts/completes the request this cycle.
REQ-017 mem_rdata  input  DATA_W  read data, valid when mem_ready is high.
REQ-018 err  output  1  sticky timeout flag.

Function
REQ-019 FSM states: IDLE, REQ, DONE.
REQ-020 IDLE with core_req=1: latch core_we/core_adr/core_wdata into mem_* registers; go to REQ.
REQ-021 IDLE with core_req=0: remain in IDLE; mem_valid=0.
REQ-022 core_stall = (IDLE and core_req) or REQ; stall is combinational, asserted in the same cycle as the request.
REQ-023 REQ: mem_valid=1; mem_we/mem_adr/mem_wdata stable until the handshake completes.
REQ-024 REQ with mem_ready=1: capture mem_rdata into core_rdata (reads only; writes leave core_rdata unchanged); go to DONE.
REQ-025 mem_ready sampled in IDLE or DONE is ignored.
REQ-026 DONE: core_stall=0, mem_valid=0, core_rdata valid; core_req is ignored; next state is IDLE unconditionally.
REQ-027 Minimum latency: request in cycle N, mem_ready in N+1, core_stall low in N+2; back-to-back accesses incur one IDLE bubble.
REQ-028 Memory-side zero wait states: the first REQ cycle may complete.

Reset
REQ-029 Reset at any time, including mid-REQ, forces IDLE.
REQ-030 Reset values: mem_valid=0, mem_we=0, mem_adr=0, mem_wdata=0, core_rdata=0, err=0, core_stall=0 (with core_req=0).
REQ-031 A request aborted by reset is not retried.

Configuration
REQ-032 Macro MEM_REQ_TIMEOUT_EN defined: a wait counter clears on entry to REQ and increments on each REQ cycle with mem_ready=0.
REQ-033 When the count reaches TIMEOUT_CYC: drop mem_valid, set err, load core_rdata=0, go to DONE.
REQ-034 err stays set until reset.
REQ-035 mem_ready on the timeout cycle takes priority: normal completion, no error.
REQ-036 Macro undefined: REQ waits indefinitely, no counter is built, and err is tied to 0.

Structure
REQ-037 Shared package holds the state enum (IDLE/REQ/DONE) and the default ADDR_W/DATA_W/TIMEOUT_CYC constants.
REQ-038 One sub-module, mem_tmo_cnt (clear, enable, terminal-count output), is instantiated only under MEM_REQ_TIMEOUT_EN.

Verification
REQ-039 Read, zero wait: core_req=1, we=0, adr=0x40; mem_ready in next cycle with rdata=0xDEADBEEF -> stall high 2 cycles, then core_rdata=0xDEADBEEF with stall=0.
REQ-040 Write, 3 waits: adr=0x80, wdata=0x12345678, mem_ready after 3 cycles -> mem_valid high 4 cycles, mem_adr/mem_wdata stable, core_rdata unchanged.
REQ-041 Back-to-back: two reads issued consecutively -> exactly one IDLE cycle between DONE and the second REQ.
REQ-042 Timeout (macro defined, TIMEOUT_CYC=4): mem_ready never asserted -> after 4 wait cycles mem_valid=0, err=1, core_rdata=0, stall low one cycle later.
REQ-043 Ready on the timeout cycle: mem_ready asserted on cycle 4 with rdata=0xA5A5A5A5 -> err stays 0, core_rdata=0xA5A5A5A5.
REQ-044 Reset mid-REQ: assert reset on 2nd wait cycle -> outputs immediately at reset values, IDLE, no later memory request for that access.
